recon_4x4: RTL and testbench
============================

# recon_4x4

Reconstruction stage directly downstream of the transform coder. Buffers the 4x4 prediction block for every block entering the coder in a prediction FIFO. When the coder emits the reconstructed residual block (`processedres`), the stage adds it to the matching prediction and clips the sum to pixel range. The resulting registered 4x4 block feeds the reference-frame store and intra predictor.

## Interface
- `DEPTH`, default 4: prediction FIFO depth in blocks. Power of two, ≥2. Must cover the blocks in flight inside the coder pipeline.
- `CNT_W`, default 3: width of `fifo_count`. Must equal log2(DEPTH)+1.
- `clk`  in  1  clock. All logic on posedge.
- `reset`  in  1  reset, synchronous, active-high; clock clk.
- `pred_valid`  in  1  prediction block presented. Asserted in the same cycle its residual block enters the coder.
- `pred`  in  8 x16 (unsigned [7:0] [15:0])  prediction pixels, raster order, index 0 = top-left.
- `pred_ready`  out  1  FIFO can accept a block.
- `res_valid`  in  1  coder output block valid this cycle. Driven by the coder's `pipeline_full` qualified per block.
- `res`  in  8 x16 (signed [7:0] [15:0])  reconstructed residuals, same ordering.
- `recon_valid`  out  1  reconstructed block valid, single-cycle pulse per block.
- `recon`  out  8 x16 (unsigned [7:0] [15:0])  reconstructed pixels.
- `fifo_count`  out  CNT_W  predictions currently buffered.
- `err_underflow`  out  1  sticky. Set when a residual block arrived with no buffered prediction.

## Operation
- FIFO storage: DEPTH entries of 128 bits, with a write pointer, a read pointer (both log2(DEPTH) bits, wrap modulo DEPTH) and a CNT_W-bit count.
- `pred_ready` = (count != DEPTH). It depends only on registered count, never on `res_valid`.
- Push: `pred_valid && pred_ready`. Writes `pred` at wr_ptr, then wr_ptr+1.
- Push while full: `pred_valid` with `pred_ready`=0 is ignored. No state change.
- Pop: `res_valid && count != 0`. Reads the entry at rd_ptr, then rd_ptr+1.
- Simultaneous push and pop with count ≥1: both occur and count is unchanged.
- Simultaneous push and pop with count = 0: there is no bypass. The pop fails (underflow rule below) and the push completes, giving count = 1.
- Underflow: `res_valid` with count = 0 sets `err_underflow`. No pop, no `recon_valid`, pointers unchanged. The flag clears only on reset.
- Arithmetic per pixel: sum = zero-extended pred (10-bit signed) + sign-extended res (10-bit signed). Range −128..382.
- Result mapping: if sum < 0, output 0. If sum > 255, output 255. Otherwise output sum[7:0]. The clip behaviour is subject to Configuration.
- All 16 pixels are computed in parallel. There is no state machine beyond the FIFO control.

## Timing
- Reset values: `recon_valid`=0, `recon`=all 0, `fifo_count`=0, `err_underflow`=0, `pred_ready`=1, pointers 0. FIFO contents are don't-care.
- Reset priority: reset overrides push, pop and output in the same cycle.
- Reset mid-operation: buffered predictions are discarded. An output that would have been produced in the reset cycle is dropped.
- Latency: `recon`/`recon_valid` are registered one cycle after the `res_valid` edge that pops.
- `recon` holds its last value while `recon_valid`=0.
- `fifo_count` reflects push/pop one cycle after the qualifying edge.
- Back-to-back `res_valid` on consecutive cycles pops consecutive entries. This yields consecutive `recon_valid` pulses.
- Throughput: one push and one pop per cycle.

## Configuration
- `RECON_CLIP_EN`, defined: saturating clip to 0..255 as described in Operation. This is the production setting.
- `RECON_CLIP_EN`, undefined: the output is sum[7:0], i.e. wrap modulo 256 with no saturation. This saves comparators for lossless/debug builds where the sum is guaranteed in range.
- The macro affects nothing else: ports, latency and FIFO behaviour are identical in both builds.

## Test plan
- Single block, clip build: push pred = all 100. Two cycles later `res_valid`, res = all +20. Next cycle `recon_valid`=1, recon = all 120, `fifo_count` returns to 0.
- Saturation, clip build: pred = 250/5, res = +10/−10. Recon = 255/0. Same stimulus in the no-clip build gives 4/251.
- Full FIFO (DEPTH=4): push 5 blocks on consecutive cycles. `pred_ready` drops after the 4th, the 5th is ignored, `fifo_count`=4. Then 4 `res_valid` pops return predictions 1–4 in order.
- Underflow: `res_valid` with empty FIFO gives `err_underflow`=1, no `recon_valid`, count stays 0. The flag persists through later normal blocks until reset.
- Simultaneous push/pop at count=2: count stays 2 and the popped entry is the oldest. Push/pop at count=0 gives underflow set and count=1.
- Reset mid-stream: with 3 buffered blocks, assert reset concurrent with `res_valid`. Result: no `recon_valid`, count 0, `pred_ready`=1, `recon` all 0.

Source files
------------

// File: rtl/recon_4x4.sv
// recon_4x4: prediction FIFO plus per-pixel pred+res reconstruction for 4x4 blocks.
// Define RECON_CLIP_EN for saturating 0..255 output; otherwise the sum wraps modulo 256.
module recon_4x4 #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [15:0][7:0] pred,
    output logic             pred_ready,
    input  logic             res_valid,
    input  logic [15:0][7:0] res,
    output logic             recon_valid,
    output logic [15:0][7:0] recon,
    output logic [CNT_W-1:0] fifo_count,
    output logic             err_underflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [15:0][7:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_recon_valid;
    logic [15:0][7:0] r_recon;
    logic             r_err_underflow;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [15:0][7:0] w_head;
    logic signed [9:0] w_sum [16];
    logic [15:0][7:0] w_recon;

    assign w_empty    = (r_count == '0);
    assign pred_ready = (r_count != CNT_W'(DEPTH));
    assign w_push     = pred_valid && pred_ready;
    assign w_pop      = res_valid && !w_empty;
    assign w_head     = r_mem[r_rd_ptr];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_sum[i] = $signed({2'b00, w_head[i]}) + $signed({{2{res[i][7]}}, res[i]});
`ifdef RECON_CLIP_EN
            // Sum spans -128..382: bit 9 flags negative, bit 8 flags >255.
            if (w_sum[i][9]) begin
                w_recon[i] = 8'd0;
            end else if (w_sum[i][8]) begin
                w_recon[i] = 8'd255;
            end else begin
                w_recon[i] = w_sum[i][7:0];
            end
`else
            w_recon[i] = w_sum[i][7:0];
`endif
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= pred;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_recon_valid   <= 1'b0;
            r_recon         <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_recon  <= w_recon;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            r_recon_valid <= w_pop;
            if (res_valid && w_empty) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign recon_valid   = r_recon_valid;
    assign recon         = r_recon;
    assign fifo_count    = r_count;
    assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_recon_4x4.sv
// Directed bench for recon_4x4 with immediate-assertion checks.
// Expected saturation values follow RECON_CLIP_EN the same way the design build does.
module tb_recon_4x4;
    logic             clk;
    logic             reset;
    logic             pred_valid;
    logic [15:0][7:0] pred;
    logic             pred_ready;
    logic             res_valid;
    logic [15:0][7:0] res;
    logic             recon_valid;
    logic [15:0][7:0] recon;
    logic [2:0]       fifo_count;
    logic             err_underflow;

    int n_total;
    int n_pass;

    recon_4x4 #(.DEPTH(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .pred_valid   (pred_valid),
        .pred         (pred),
        .pred_ready   (pred_ready),
        .res_valid    (res_valid),
        .res          (res),
        .recon_valid  (recon_valid),
        .recon        (recon),
        .fifo_count   (fifo_count),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [127:0] sat_exp;
        n_total    = 0;
        n_pass     = 0;
        reset      = 1'b1;
        pred_valid = 1'b0;
        pred       = '0;
        res_valid  = 1'b0;
        res        = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 128'(recon_valid), 128'(0));
        check("rst_recon", recon, 128'(0));
        check("rst_count", 128'(fifo_count), 128'(0));
        check("rst_err", 128'(err_underflow), 128'(0));
        check("rst_ready", 128'(pred_ready), 128'(1));

        // Single block: 100 + 20
        pred_valid = 1'b1; pred = fill(8'd100);
        tick();
        pred_valid = 1'b0;
        check("single_cnt1", 128'(fifo_count), 128'(1));
        tick();
        res_valid = 1'b1; res = fill(8'd20);
        tick();
        res_valid = 1'b0;
        check("single_valid", 128'(recon_valid), 128'(1));
        check("single_recon", recon, fill(8'd120));
        check("single_cnt0", 128'(fifo_count), 128'(0));
        tick();
        check("pulse_end", 128'(recon_valid), 128'(0));
        check("recon_hold", recon, fill(8'd120));

        // Negative residual in range: 50 - 20
        pred_valid = 1'b1; pred = fill(8'd50);
        tick();
        pred_valid = 1'b0; res_valid = 1'b1; res = fill(8'hEC);
        tick();
        res_valid = 1'b0;
        check("neg_res", recon, fill(8'd30));

        // Saturation: 250+10 / 5-10
        pred_valid = 1'b1; pred = {8{8'd5, 8'd250}};
        tick();
        pred_valid = 1'b0; res_valid = 1'b1; res = {8{8'hF6, 8'h0A}};
        tick();
        res_valid = 1'b0;
`ifdef RECON_CLIP_EN
        sat_exp = {8{8'd0, 8'd255}};
`else
        sat_exp = {8{8'd251, 8'd4}};
`endif
        check("saturate", recon, sat_exp);

        // Full FIFO: 5 pushes, 5th ignored
        pred_valid = 1'b1;
        pred = fill(8'd1); tick();
        pred = fill(8'd2); tick();
        pred = fill(8'd3); tick();
        check("ready_at3", 128'(pred_ready), 128'(1));
        pred = fill(8'd4); tick();
        check("ready_full", 128'(pred_ready), 128'(0));
        pred = fill(8'd5); tick();
        pred_valid = 1'b0;
        check("full_cnt", 128'(fifo_count), 128'(4));
        res_valid = 1'b1; res = '0;
        tick();
        check("pop1", recon, fill(8'd1));
        tick();
        check("pop2", recon, fill(8'd2));
        check("pop2_valid", 128'(recon_valid), 128'(1));
        tick();
        check("pop3", recon, fill(8'd3));
        tick();
        res_valid = 1'b0;
        check("pop4", recon, fill(8'd4));
        check("drain_cnt", 128'(fifo_count), 128'(0));
        check("drain_ready", 128'(pred_ready), 128'(1));

        // Underflow
        res_valid = 1'b1; res = fill(8'd5);
        tick();
        res_valid = 1'b0;
        check("uf_err", 128'(err_underflow), 128'(1));
        check("uf_novalid", 128'(recon_valid), 128'(0));
        check("uf_cnt", 128'(fifo_count), 128'(0));
        check("uf_hold", recon, fill(8'd4));
        pred_valid = 1'b1; pred = fill(8'd7);
        tick();
        pred_valid = 1'b0; res_valid = 1'b1; res = fill(8'd1);
        tick();
        res_valid = 1'b0;
        check("post_uf_recon", recon, fill(8'd8));
        check("uf_sticky", 128'(err_underflow), 128'(1));

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("err_cleared", 128'(err_underflow), 128'(0));

        // Push/pop at count 2
        pred_valid = 1'b1;
        pred = fill(8'd11); tick();
        pred = fill(8'd22); tick();
        pred = fill(8'd33); res_valid = 1'b1; res = '0;
        tick();
        pred_valid = 1'b0;
        check("pp2_cnt", 128'(fifo_count), 128'(2));
        check("pp2_oldest", recon, fill(8'd11));
        check("pp2_err", 128'(err_underflow), 128'(0));
        tick();
        check("pp2_next", recon, fill(8'd22));
        tick();
        res_valid = 1'b0;
        check("pp2_last", recon, fill(8'd33));
        check("pp2_drained", 128'(fifo_count), 128'(0));

        // Push/pop at count 0: no bypass
        pred_valid = 1'b1; pred = fill(8'd44); res_valid = 1'b1; res = '0;
        tick();
        pred_valid = 1'b0; res_valid = 1'b0;
        check("pp0_cnt", 128'(fifo_count), 128'(1));
        check("pp0_err", 128'(err_underflow), 128'(1));
        check("pp0_novalid", 128'(recon_valid), 128'(0));
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        check("pp0_pop", recon, fill(8'd44));

        // Reset mid-stream with 3 buffered blocks
        pred_valid = 1'b1;
        pred = fill(8'd61); tick();
        pred = fill(8'd62); tick();
        pred = fill(8'd63); tick();
        pred_valid = 1'b0;
        check("mid_cnt3", 128'(fifo_count), 128'(3));
        reset = 1'b1; res_valid = 1'b1; res = '0;
        tick();
        reset = 1'b0; res_valid = 1'b0;
        check("mid_novalid", 128'(recon_valid), 128'(0));
        check("mid_cnt", 128'(fifo_count), 128'(0));
        check("mid_ready", 128'(pred_ready), 128'(1));
        check("mid_recon", recon, 128'(0));
        check("mid_err", 128'(err_underflow), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
